// File: rtl/account_balance.sv
// account_balance: saturating deposit/withdraw balance with sequential double-dabble BCD conversion
module account_balance #(
  parameter int WIDTH    = 14,
  parameter int DIGITS   = 4,
  parameter int STEP     = 1,
  parameter int MAX_BAL  = 9999,
  parameter int INIT_BAL = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  count_up,
  input  logic                  count_down,
  output logic [WIDTH-1:0]      balance,
  output logic [4*DIGITS-1:0]   bcd_digits,
  output logic                  bcd_valid,
  output logic                  overflow_err,
  output logic                  underflow_err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_bal, r_snap;
  logic [4*DIGITS-1:0] r_scr, r_bcd, w_adj;
  logic [CW-1:0] r_cnt;
  logic r_pend, r_valid, r_ovf, r_udf;
  logic [WIDTH:0] w_sum;
  logic w_inc, w_dec, w_cap;
  assign w_sum = {1'b0, r_bal} + (WIDTH+1)'(STEP);
  assign w_inc = count_up & ~count_down & (w_sum <= (WIDTH+1)'(MAX_BAL));
  assign w_dec = count_down & ~count_up & (r_bal >= WIDTH'(STEP));
  assign w_cap = (r_state == IDLE) & r_pend;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign w_adj[4*i+:4] = r_scr[4*i+:4] >= 4'd5 ? r_scr[4*i+:4] + 4'd3 : r_scr[4*i+:4];
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (r_pend ? SHIFT : IDLE) :
             r_state == SHIFT ? (r_cnt == CW'(WIDTH - 1) ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bal   <= WIDTH'(INIT_BAL);
      r_pend  <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_valid <= 1'b0;
      r_bcd   <= '0;
      r_snap  <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_bal   <= w_inc ? w_sum[WIDTH-1:0] : w_dec ? r_bal - WIDTH'(STEP) : r_bal;
      r_ovf   <= count_up & ~count_down & ~w_inc;
      r_udf   <= count_down & ~count_up & ~w_dec;
      // a change on the capture edge must re-arm pending, so set wins over clear
      r_pend  <= w_inc | w_dec | (r_pend & ~w_cap);
      r_valid <= r_state == DONE;
      if (w_cap) begin
        r_snap <= r_bal;
        r_scr  <= '0;
        r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
        {r_scr, r_snap} <= {w_adj, r_snap} << 1;
        r_cnt           <= r_cnt + CW'(1);
      end
      if (r_state == DONE) r_bcd <= r_scr;
    end
  end
  assign balance       = r_bal;
  assign bcd_digits    = r_bcd;
  assign bcd_valid     = r_valid;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_udf;
endmodule

// File: tb/tb_account_balance.sv
// tb_account_balance: randomized scoreboard bench against an integer reference model
module tb_account_balance;
  localparam int W = 14, D = 4, STEP = 1, MAXB = 9999, INIT = 0;
  logic clk = 1'b1, reset = 1'b0, count_up = 1'b0, count_down = 1'b0;
  logic [W-1:0] balance;
  logic [4*D-1:0] bcd_digits;
  logic bcd_valid, overflow_err, underflow_err;
  account_balance #(.WIDTH(W), .DIGITS(D), .STEP(STEP), .MAX_BAL(MAXB), .INIT_BAL(INIT)) dut (
    .clk(clk), .reset(reset), .count_up(count_up), .count_down(count_down),
    .balance(balance), .bcd_digits(bcd_digits), .bcd_valid(bcd_valid),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int bal; bit ovf; bit udf; bit rst;} cyc_t;
  typedef struct {int val; int at;} bcd_t;
  cyc_t exp_q[$];
  bcd_t bcd_q[$];
  int checks = 0, errors = 0;
  int m_bal = 0, m_done = 0;
  bit m_pend = 1'b0;
  function automatic int to_bcd(int v);
    int r;
    r = 0;
    for (int i = 0; i < D; i++) begin
      r += (v % 10) << (4 * i);
      v /= 10;
    end
    return r;
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", n, cyc, got, exp);
    end
  endtask
  // Drives one cycle and records what the account must look like after the coming edge.
  task automatic step(input bit r, input bit u, input bit d);
    cyc_t e;
    int k;
    @(negedge clk);
    reset = r;
    count_up = u;
    count_down = d;
    k = cyc + 1;
    e.rst = r;
    e.ovf = 1'b0;
    e.udf = 1'b0;
    if (r) begin
      m_bal = INIT;
      m_pend = 1'b1;
      m_done = k;
      bcd_q.delete();
    end else begin
      if (m_pend && k > m_done) begin
        m_done = k + W + 1;
        bcd_q.push_back('{to_bcd(m_bal), m_done});
        m_pend = 1'b0;
      end
      if (u && !d) begin
        if (m_bal + STEP <= MAXB) begin m_bal += STEP; m_pend = 1'b1; end
        else e.ovf = 1'b1;
      end else if (d && !u) begin
        if (m_bal >= STEP) begin m_bal -= STEP; m_pend = 1'b1; end
        else e.udf = 1'b1;
      end
    end
    e.bal = m_bal;
    exp_q.push_back(e);
  endtask
  initial begin
    cyc_t e;
    bcd_t b;
    int last_bcd;
    last_bcd = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.rst) last_bcd = 0;
        chk("balance", int'(balance), e.bal);
        chk("overflow_err", int'(overflow_err), int'(e.ovf));
        chk("underflow_err", int'(underflow_err), int'(e.udf));
        if (bcd_valid) begin
          if (bcd_q.size() == 0) chk("bcd_valid_unexpected", 1, 0);
          else begin
            b = bcd_q.pop_front();
            chk("bcd_valid_cycle", cyc, b.at);
            chk("bcd_value", int'(bcd_digits), b.val);
            last_bcd = b.val;
          end
        end else if (bcd_q.size() > 0 && bcd_q[0].at <= cyc) begin
          b = bcd_q.pop_front();
          chk("bcd_valid_missing", 0, b.at);
        end
        chk("bcd_hold", int'(bcd_digits), last_bcd);
      end
    end
  end
  initial begin
    repeat (2) step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    repeat (3) begin step(0, 1, 0); repeat (19) step(0, 0, 0); end
    step(1, 0, 0); repeat (20) step(0, 0, 0);
    step(0, 0, 1); repeat (20) step(0, 0, 0);
    repeat (5) step(0, 1, 0); repeat (40) step(0, 0, 0);
    step(0, 1, 1); repeat (40) step(0, 0, 0);
    step(1, 0, 0); repeat (20) step(0, 0, 0);
    repeat (4) step(0, 1, 0); repeat (40) step(0, 0, 0);
    repeat (7) step(0, 1, 0); repeat (5) step(0, 0, 0);
    step(1, 0, 0); repeat (40) step(0, 0, 0);
    for (int blk = 0; blk < 60; blk++) begin
      int pu, pd;
      pu = $urandom_range(0, 100);
      pd = $urandom_range(0, 100);
      repeat (50) step($urandom_range(0, 599) == 0, $urandom_range(0, 99) < pu, $urandom_range(0, 99) < pd);
    end
    // full-scale ramps to exercise the 9999 ceiling and the zero floor
    repeat (10010) step(0, 1, 0);
    repeat (40) step(0, 0, 0);
    step(0, 1, 0); repeat (20) step(0, 0, 0);
    repeat (10010) step(0, 0, 1);
    repeat (40) step(0, 0, 0);
    for (int i = 0; i < 200 && bcd_q.size() > 0; i++) step(0, 0, 0);
    chk("bcd_drain", bcd_q.size(), 0);
    repeat (20) step(0, 0, 0);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/account_balance.md
Name: account_balance

Overview:
- Receiving end of the deposit/withdraw pulse interface.
- Consumes the one-cycle count_up pulses from the deposit controller and the count_down pulses from the withdraw controller.
- Holds the account balance, with saturation and error checks.
- Converts the balance to packed BCD with a sequential double-dabble FSM, for the seven-segment display path.

Parameters:
- WIDTH, 14, balance register width in bits; MAX_BAL must be < 2^WIDTH.
- DIGITS, 4, number of BCD digits output; MAX_BAL must be < 10^DIGITS.
- STEP, 1, amount added or removed per pulse.
- MAX_BAL, 9999, upper balance limit.
- INIT_BAL, 0, balance after reset; must be <= MAX_BAL.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- count_up  in  1  deposit pulse, sampled each edge
- count_down  in  1  withdraw pulse, sampled each edge
- balance  out  WIDTH  current binary balance
- bcd_digits  out  4*DIGITS  packed BCD of last converted balance; digit 0 in bits [3:0]
- bcd_valid  out  1  one-cycle pulse when bcd_digits is updated
- overflow_err  out  1  one-cycle pulse: rejected deposit
- underflow_err  out  1  one-cycle pulse: rejected withdrawal

Behaviour:
- Clock and reset: single clock domain (clk). reset is synchronous and active-high.
- Reset values: balance=INIT_BAL, bcd_digits=0, bcd_valid=0, overflow_err=0, underflow_err=0, FSM=IDLE, pending=1. A reset asserted mid-conversion aborts it immediately.
- Balance update, evaluated at each edge where reset=0:
  - count_up and count_down both 1: balance unchanged, no error pulse.
  - count_up only, balance+STEP <= MAX_BAL: balance += STEP.
  - count_up only, otherwise: balance unchanged; overflow_err=1 for the next cycle.
  - count_down only, balance >= STEP: balance -= STEP.
  - count_down only, otherwise: balance unchanged; underflow_err=1 for the next cycle.
  - Compute the sum at WIDTH+1 bits so it cannot wrap.
  - A held-high input is treated as one pulse per cycle; there is no edge detection in this block.
- pending flag:
  - Set on any edge where balance changes value.
  - Cleared when the FSM captures a snapshot.
  - Rejected or net-zero requests do not set pending.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: if pending, capture snapshot=balance, clear the BCD scratch, shift counter=0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch digit >= 5, then shift {scratch, snapshot} left by 1 and increment the counter. After WIDTH shifts, go to DONE.
  - DONE: load bcd_digits from scratch, assert bcd_valid for this one cycle, return to IDLE.
  - Latency: the edge that changes balance is E0. The snapshot is taken at E1. bcd_valid is high in the cycle after edge E0+WIDTH+2 (16 cycles with the defaults).
  - Balance changes during SHIFT or DONE only set pending. The FSM finishes the current conversion, publishes the stale snapshot, then immediately restarts from IDLE. bcd_digits therefore always converges to the final balance.
  - After reset, pending=1, so INIT_BAL is converted automatically.
- Outputs:
  - All outputs are registered.
  - bcd_digits holds its value between bcd_valid pulses.
  - Error pulses are independent of the FSM and never trigger a conversion.

Test Plan:
1. Reset, then three single-cycle count_up pulses spaced 20 cycles apart -> balance 1, 2, 3. Three bcd_valid pulses; the final one shows bcd_digits=16'h0003, exactly 16 cycles after the third update.
2. Reset (balance 0), then count_down for one cycle -> balance stays 0. underflow_err high for exactly 1 cycle. No bcd_valid beyond the post-reset conversion.
3. INIT_BAL=9998, two count_up pulses -> balance 9999 with bcd_digits=16'h9999. The second pulse gives overflow_err for 1 cycle, balance stays 9999, and no new conversion starts.
4. Balance 5, count_up and count_down high in the same cycle -> balance stays 5. No error pulses, no bcd_valid.
5. Balance 0, count_up held high for 4 consecutive cycles -> balance 4. An intermediate bcd_valid shows the stale snapshot (0x0001), and the final bcd_valid shows 16'h0004. No further bcd_valid afterwards.
6. Balance 7 with conversion in SHIFT, reset for 1 cycle -> all outputs at reset values on the next cycle. After release, the first bcd_valid shows 16'h0000 (INIT_BAL) 16 cycles later.
